// File: rtl/calc_seq_ctrl_pkg.sv
// Shared key codes, state encodings and key classification for the calculator controller.
package calc_seq_ctrl_pkg;

    localparam logic [3:0] KEY_EQ  = 4'd10;
    localparam logic [3:0] KEY_AC  = 4'd11;
    localparam logic [3:0] KEY_ADD = 4'd12;
    localparam logic [3:0] KEY_SUB = 4'd13;
    localparam logic [3:0] KEY_MUL = 4'd14;
    localparam logic [3:0] KEY_DIV = 4'd15;

    localparam logic [3:0] BCD_ERR = 4'hE;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_WAIT_ALU = 3'd2,
        ST_SHOW_RES = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KC_DIGIT,
        KC_EQ,
        KC_AC,
        KC_OP
    } key_class_t;

    function automatic key_class_t classify_key(input logic [3:0] code);
        key_class_t kc;
        case (code)
            KEY_EQ:                             kc = KC_EQ;
            KEY_AC:                             kc = KC_AC;
            KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: kc = KC_OP;
            default:                            kc = KC_DIGIT;
        endcase
        return kc;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// ALU start/done handshake bundle between the calculator controller (master) and the ALU (slave).
interface calc_seq_ctrl_if #(
    parameter int W = 16
);
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_op;
    logic         alu_start;
    logic [W-1:0] alu_res;
    logic         alu_err;
    logic         alu_done;

    modport master (
        output alu_a, alu_b, alu_op, alu_start,
        input  alu_res, alu_err, alu_done
    );

    modport slave (
        input  alu_a, alu_b, alu_op, alu_start,
        output alu_res, alu_err, alu_done
    );
endinterface

// File: rtl/calc_seq_ctrl_key_sync.sv
// Two-flop synchroniser for the keypad strobe followed by a one-cycle rising-edge pulse.
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic pulse_o
);
    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    // sync_q[1] is the synchronised level; sync_q[2] is its previous value.
    assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator main controller: BCD operand entry from keypad, ALU handshake with operator
// chaining and repeat-equals, and a registered BCD display.
module calc_seq_ctrl
    import calc_seq_ctrl_pkg::*;
#(
    parameter int NDIGITS     = 4,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [3:0]             key_code,
    calc_seq_ctrl_if.master        alu,
    output logic [4*NDIGITS-1:0]   display,
    output logic                   err,
    output logic [2:0]             state_dbg
);
    localparam int W  = 4 * NDIGITS;
    localparam int CW = $clog2(ALU_TIMEOUT + 1);
    localparam int NW = $clog2(NDIGITS + 1);

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] res_q, res_d;
    logic [3:0]   op_q, op_d;
    logic [3:0]   pend_op_q, pend_op_d;
    logic [NW-1:0] ndig_q, ndig_d;
    logic         chain_q, chain_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         start_q, start_d;
    logic [W-1:0] disp_q, disp_d;

    logic         key_pulse;
    key_class_t   kc;
    logic         full_clr;
    logic         enter_wait;

    key_sync_edge u_key_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (key_valid),
        .pulse_o (key_pulse)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        res_d      = res_q;
        op_d       = op_q;
        pend_op_d  = pend_op_q;
        ndig_d     = ndig_q;
        chain_d    = chain_q;
        cnt_d      = cnt_q;
        full_clr   = 1'b0;
        enter_wait = 1'b0;
        kc         = classify_key(key_code);

        case (state_q)
            ST_ENTER_A: begin
                if (key_pulse) begin
                    case (kc)
                        KC_DIGIT: begin
                            if (ndig_q != NW'(NDIGITS)) begin
                                a_d    = W'({a_q, key_code});
                                ndig_d = ndig_q + 1'b1;
                            end
                        end
                        KC_OP: begin
                            op_d    = key_code;
                            b_d     = '0;
                            ndig_d  = '0;
                            state_d = ST_ENTER_B;
                        end
                        KC_AC: begin
                            if (a_q != '0) begin
                                a_d    = '0;
                                ndig_d = '0;
                            end else begin
                                full_clr = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_ENTER_B: begin
                if (key_pulse) begin
                    case (kc)
                        KC_DIGIT: begin
                            if (ndig_q != NW'(NDIGITS)) begin
                                b_d    = W'({b_q, key_code});
                                ndig_d = ndig_q + 1'b1;
                            end
                        end
                        KC_OP: begin
                            if (ndig_q == '0) begin
                                op_d = key_code;
                            end else begin
                                chain_d    = 1'b1;
                                pend_op_d  = key_code;
                                enter_wait = 1'b1;
                            end
                        end
                        KC_EQ: begin
                            chain_d    = 1'b0;
                            enter_wait = 1'b1;
                        end
                        KC_AC: begin
                            if (b_q != '0) begin
                                b_d    = '0;
                                ndig_d = '0;
                            end else begin
                                full_clr = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT_ALU: begin
                cnt_d = cnt_q + 1'b1;
                // AC has priority over a completion arriving in the same cycle.
                if (key_pulse && kc == KC_AC) begin
                    full_clr = 1'b1;
                end else if (alu.alu_done && !alu.alu_err) begin
                    res_d = alu.alu_res;
                    if (chain_q) begin
                        a_d     = alu.alu_res;
                        op_d    = pend_op_q;
                        b_d     = '0;
                        ndig_d  = '0;
                        chain_d = 1'b0;
                        state_d = ST_ENTER_B;
                    end else begin
                        state_d = ST_SHOW_RES;
                    end
                end else if (alu.alu_done || cnt_q == CW'(ALU_TIMEOUT)) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SHOW_RES: begin
                if (key_pulse) begin
                    case (kc)
                        KC_DIGIT: begin
                            a_d     = W'(key_code);
                            b_d     = '0;
                            ndig_d  = NW'(1);
                            state_d = ST_ENTER_A;
                        end
                        KC_OP: begin
                            a_d     = res_q;
                            op_d    = key_code;
                            b_d     = '0;
                            ndig_d  = '0;
                            state_d = ST_ENTER_B;
                        end
                        KC_EQ: begin
                            a_d        = res_q;
                            chain_d    = 1'b0;
                            enter_wait = 1'b1;
                        end
                        default: full_clr = 1'b1;
                    endcase
                end
            end
            ST_ERROR: begin
                if (key_pulse && kc == KC_AC) begin
                    full_clr = 1'b1;
                end
            end
            default: full_clr = 1'b1;
        endcase

        if (enter_wait) begin
            state_d = ST_WAIT_ALU;
            cnt_d   = CW'(1);
        end

        if (full_clr) begin
            state_d   = ST_ENTER_A;
            a_d       = '0;
            b_d       = '0;
            res_d     = '0;
            op_d      = KEY_ADD;
            pend_op_d = KEY_ADD;
            ndig_d    = '0;
            chain_d   = 1'b0;
        end
    end

    always_comb begin
        start_d = (state_d == ST_WAIT_ALU) && (state_q != ST_WAIT_ALU || enter_wait);
        disp_d  = disp_q;
        case (state_q)
            ST_ENTER_A:  disp_d = a_q;
            ST_ENTER_B:  disp_d = (ndig_q == '0) ? a_q : b_q;
            ST_SHOW_RES: disp_d = res_q;
            ST_ERROR:    disp_d = {NDIGITS{BCD_ERR}};
            default:     disp_d = disp_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= KEY_ADD;
            pend_op_q <= KEY_ADD;
            ndig_q    <= '0;
            chain_q   <= 1'b0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            disp_q    <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            op_q      <= op_d;
            pend_op_q <= pend_op_d;
            ndig_q    <= ndig_d;
            chain_q   <= chain_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            disp_q    <= disp_d;
        end
    end

    assign alu.alu_a     = a_q;
    assign alu.alu_b     = b_q;
    assign alu.alu_op    = op_q;
    assign alu.alu_start = start_q;
    assign display       = disp_q;
    assign err           = (state_q == ST_ERROR);
    assign state_dbg     = state_q;

endmodule
